// File: rtl/serial_to_parallel_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: default width,
// counter sizing helper and output FSM state encoding.
package serial_to_parallel_pkg;

    localparam int WIDTH_DEF = 32;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Serial input, parallel output handshake and status bundle of the deserializer.
interface serial_to_parallel_if
    import serial_to_parallel_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    localparam int CNT_W = cnt_width(WIDTH);

    logic             S_IN;
    logic             S_VALID;
    logic             S_SYNC;
    logic [WIDTH-1:0] P_OUT;
    logic             P_VALID;
    logic             P_READY;
    logic             OVERRUN;
    logic             OVR_CLR;
    logic [CNT_W-1:0] BIT_CNT;

    modport master (
        output S_IN, S_VALID, S_SYNC, P_READY, OVR_CLR,
        input  P_OUT, P_VALID, OVERRUN, BIT_CNT
    );

    modport slave (
        input  S_IN, S_VALID, S_SYNC, P_READY, OVR_CLR,
        output P_OUT, P_VALID, OVERRUN, BIT_CNT
    );

endinterface

// File: rtl/s2p_shift_core.sv
// Shift register and bit counter: accumulates qualified serial bits and
// flags the edge that completes a word together with the completed word.
module s2p_shift_core
    import serial_to_parallel_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_in,
    input  logic                     s_valid,
    input  logic                     s_sync,
    output logic                     word_done,
    output logic [WIDTH-1:0]         word_data,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] base, shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_base;

    // Sync restarts the word on this edge, so the bit accepted with it is bit 0.
    always_comb begin
        base     = s_sync ? '0 : shift_q;
        cnt_base = s_sync ? '0 : cnt_q;
        if (MSB_FIRST) begin
            shifted = {base[WIDTH-2:0], s_in};
        end else begin
            shifted = {s_in, base[WIDTH-1:1]};
        end
        shift_d   = base;
        cnt_d     = cnt_base;
        word_done = 1'b0;
        if (s_valid) begin
            shift_d = shifted;
            if (cnt_base == CNT_LAST) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_data = shifted;
    assign bit_cnt   = cnt_q;

endmodule

// File: rtl/serial_to_parallel.sv
// Deserializer top: shift core feeding a one-word output register with
// valid/ready handshake and sticky overrun flag.
//   state    | meaning
//   ST_EMPTY | no unconsumed word, P_VALID=0
//   ST_FULL  | P_OUT holds an unconsumed word, P_VALID=1
module serial_to_parallel
    import serial_to_parallel_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    serial_to_parallel_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    logic             word_done;
    logic [WIDTH-1:0] word_data;
    logic [CNT_W-1:0] bit_cnt;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic             overrun_q, overrun_d;
    logic             ovr_set;

    s2p_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (CLK),
        .rst_n     (RESET),
        .s_in      (bus.S_IN),
        .s_valid   (bus.S_VALID),
        .s_sync    (bus.S_SYNC),
        .word_done (word_done),
        .word_data (word_data),
        .bit_cnt   (bit_cnt)
    );

    always_comb begin
        state_d = state_q;
        p_out_d = p_out_q;
        ovr_set = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (word_done) begin
                    state_d = ST_FULL;
                    p_out_d = word_data;
                end
            end
            default: begin
                if (bus.P_READY) begin
                    if (word_done) begin
                        p_out_d = word_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (word_done) begin
                    ovr_set = 1'b1;
                end
            end
        endcase
        // A drop on the same edge as a clear must stay visible.
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (bus.OVR_CLR) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_EMPTY;
            p_out_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_out_q   <= p_out_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.P_OUT   = p_out_q;
    assign bus.P_VALID = (state_q == ST_FULL);
    assign bus.OVERRUN = overrun_q;
    assign bus.BIT_CNT = bit_cnt;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed and randomized checks of serial_to_parallel (WIDTH=32, MSB first)
// against a bit-queue reference model.
module tb_serial_to_parallel;

    logic CLK;
    logic RESET;

    serial_to_parallel_if #(.WIDTH(32)) bus ();

    serial_to_parallel #(
        .WIDTH     (32),
        .MSB_FIRST (1'b1)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    bit          m_bits[$];
    logic [31:0] m_out;
    bit          m_valid;
    bit          m_ovr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_step(input bit in, input bit v, input bit sync, input bit rdy, input bit clr);
        bit          done;
        bit          set;
        logic [31:0] w;
        done = 1'b0;
        set  = 1'b0;
        w    = '0;
        if (sync) m_bits.delete();
        if (v) begin
            m_bits.push_back(in);
            if (m_bits.size() == 32) begin
                done = 1'b1;
                for (int i = 0; i < 32; i++)
                    if (m_bits[i]) w = w | (32'h1 << (31 - i));
                m_bits.delete();
            end
        end
        if (!m_valid) begin
            if (done) begin
                m_valid = 1'b1;
                m_out   = w;
            end
        end else if (rdy) begin
            if (done) m_out = w;
            else m_valid = 1'b0;
        end else if (done) begin
            set = 1'b1;
        end
        if (set) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic compare_all();
        chk("p_valid", 64'(bus.P_VALID), 64'(m_valid));
        chk("p_out",   64'(bus.P_OUT),   64'(m_out));
        chk("overrun", 64'(bus.OVERRUN), 64'(m_ovr));
        chk("bit_cnt", 64'(bus.BIT_CNT), 64'(m_bits.size()));
    endtask

    task automatic cyc(input bit in, input bit v, input bit sync, input bit rdy, input bit clr);
        bus.S_IN    = in;
        bus.S_VALID = v;
        bus.S_SYNC  = sync;
        bus.P_READY = rdy;
        bus.OVR_CLR = clr;
        model_step(in, v, sync, rdy, clr);
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic send_word(input logic [31:0] w, input bit rdy, input bit rdy_last);
        for (int i = 31; i >= 0; i--)
            cyc(w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy, 1'b0);
    endtask

    task automatic async_reset_check(input string tag);
        #2 RESET = 1'b0;
        #1;
        model_reset();
        chk({tag, "_p_out"},   64'(bus.P_OUT),   64'h0);
        chk({tag, "_p_valid"}, 64'(bus.P_VALID), 64'h0);
        chk({tag, "_overrun"}, 64'(bus.OVERRUN), 64'h0);
        chk({tag, "_bit_cnt"}, 64'(bus.BIT_CNT), 64'h0);
        bus.S_VALID = 1'b0;
        bus.S_SYNC  = 1'b0;
        bus.P_READY = 1'b0;
        bus.OVR_CLR = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        RESET       = 1'b0;
        bus.S_IN    = 1'b0;
        bus.S_VALID = 1'b0;
        bus.S_SYNC  = 1'b0;
        bus.P_READY = 1'b0;
        bus.OVR_CLR = 1'b0;
        model_reset();
        #12;
        chk("rst_p_out",   64'(bus.P_OUT),   64'h0);
        chk("rst_p_valid", 64'(bus.P_VALID), 64'h0);
        chk("rst_overrun", 64'(bus.OVERRUN), 64'h0);
        chk("rst_bit_cnt", 64'(bus.BIT_CNT), 64'h0);
        @(negedge CLK);
        RESET = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // single word, consumer always ready: valid for exactly one cycle
        send_word(32'hA5C3_0F81, 1'b1, 1'b1);
        chk("t1_p_out", 64'(bus.P_OUT), 64'hA5C3_0F81);
        chk("t1_valid_hi", 64'(bus.P_VALID), 64'h1);
        cyc(0, 0, 0, 1, 0);
        chk("t1_valid_lo", 64'(bus.P_VALID), 64'h0);

        // same word with idle gaps after bits 7 and 20
        for (int i = 31; i >= 0; i--) begin
            cyc(logic'(32'hA5C3_0F81 >> i), 1'b1, 1'b0, 1'b1, 1'b0);
            if (i == 25 || i == 12)
                for (int g = 0; g < 3; g++) begin
                    cyc(0, 0, 0, 1, 0);
                    chk("t2_gap_cnt", 64'(bus.BIT_CNT), (i == 25) ? 64'd7 : 64'd20);
                end
        end
        chk("t2_p_out", 64'(bus.P_OUT), 64'hA5C3_0F81);
        cyc(0, 0, 0, 1, 0);

        // backpressure: second word dropped
        send_word(32'h1111_1111, 1'b0, 1'b0);
        send_word(32'h2222_2222, 1'b0, 1'b0);
        chk("t3_p_out", 64'(bus.P_OUT), 64'h1111_1111);
        chk("t3_ovr", 64'(bus.OVERRUN), 64'h1);
        cyc(0, 0, 0, 1, 0);
        chk("t3_valid_drop", 64'(bus.P_VALID), 64'h0);
        cyc(0, 0, 0, 0, 1);
        chk("t3_ovr_clr", 64'(bus.OVERRUN), 64'h0);

        // back-to-back: handshake on the completion edge of the next word
        send_word(32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("t4_first", 64'(bus.P_OUT), 64'hDEAD_BEEF);
        send_word(32'h0123_4567, 1'b0, 1'b1);
        chk("t4_valid", 64'(bus.P_VALID), 64'h1);
        chk("t4_second", 64'(bus.P_OUT), 64'h0123_4567);
        chk("t4_ovr", 64'(bus.OVERRUN), 64'h0);
        cyc(0, 0, 0, 1, 0);

        // sync realigns mid-word; the sync-edge bit is bit 0
        for (int i = 0; i < 10; i++) cyc(1'($urandom_range(1)), 1, 0, 1, 0);
        cyc(1, 1, 1, 1, 0);
        chk("t5_cnt_after_sync", 64'(bus.BIT_CNT), 64'h1);
        for (int i = 30; i >= 0; i--) cyc(logic'(32'h0000_0001 >> i), 1, 0, 1, 0);
        chk("t5_word", 64'(bus.P_OUT), 64'h8000_0001);
        cyc(0, 0, 0, 1, 0);

        // async reset mid-word, then while FULL
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0);
        async_reset_check("t6_mid");
        cyc(0, 0, 0, 0, 0);
        send_word(32'hCAFE_F00D, 1'b0, 1'b0);
        chk("t6_full", 64'(bus.P_VALID), 64'h1);
        async_reset_check("t6_full");
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) cyc(1, 1, 0, 0, 0);
        chk("t6_no_valid", 64'(bus.P_VALID), 64'h0);
        cyc(0, 1, 0, 0, 0);
        chk("t6_valid", 64'(bus.P_VALID), 64'h1);
        chk("t6_word", 64'(bus.P_OUT), 64'hFFFF_FFFE);
        cyc(0, 0, 0, 1, 1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++)
            cyc(1'($urandom_range(1)),
                ($urandom_range(99) < 75),
                ($urandom_range(199) < 3),
                ($urandom_range(99) < 50),
                ($urandom_range(99) < 5));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
